// File: rtl/alu_seq_ctrl_pkg.sv
// Shared constants, FSM encoding and opcode arithmetic for the ALU demo controller.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_SHOW = 2'd3;

  localparam int unsigned BTN_C = 4;
  localparam int unsigned BTN_U = 3;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_L = 1;
  localparam int unsigned BTN_R = 0;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StExec = ST_EXEC,
    StWait = ST_WAIT,
    StShow = ST_SHOW
  } state_t;

  // Apply the highest-priority direction event; lower events that cycle are dropped.
  // Arithmetic wraps modulo 8 through the 3-bit width.
  function automatic logic [OP_W-1:0] op_step(input logic [OP_W-1:0] op, input logic [4:0] ev);
    logic [OP_W-1:0] nxt;
    nxt = op;
    if (ev[BTN_U])      nxt = op + 3'd2;
    else if (ev[BTN_D]) nxt = op - 3'd2;
    else if (ev[BTN_L]) nxt = op + 3'd1;
    else if (ev[BTN_R]) nxt = op - 3'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Controller-to-ALU bus: opcode, operands, execute strobe and returned result.
interface alu_seq_ctrl_if
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 4
);
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_en;
  logic [DATA_W-1:0] alu_res;

  modport master (output alu_op, output alu_a, output alu_b, output alu_en, input alu_res);
  modport slave  (input alu_op, input alu_a, input alu_b, input alu_en, output alu_res);
endinterface

// File: rtl/alu_seq_ctrl_btn_debounce.sv
// One button: 2-FF synchroniser, stability-window debounce, rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DB_CNT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int unsigned CntW = $clog2(DB_CNT);

  logic            sync0_q, sync1_q;
  logic            stable_q, prev_q;
  logic [CntW-1:0] cnt_q;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= raw;
      sync1_q <= sync0_q;
    end
  end

  // Accept a new level only after it has differed from stable for DB_CNT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync1_q == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntW'(DB_CNT - 1)) begin
      stable_q <= sync1_q;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= stable_q;
  end

  // Only the press edge matters; release produces nothing.
  assign press = stable_q & ~prev_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Button-driven sequencer for the ALU demo: edits opcode, launches one operation, captures result.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned DB_CNT  = 1000000,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        btn,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  alu_seq_ctrl_if.master    alu,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LatW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  logic [4:0] press;

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(
      .DB_CNT(DB_CNT)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn[i]),
      .press(press[i])
    );
  end

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic              en_c, busy_c, done_c;
  logic              has_dir;

  assign has_dir = |press[BTN_U:BTN_R];

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state and strobes; events outside IDLE/SHOW fall through and are lost.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    lat_d   = lat_q;
    en_c    = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press[BTN_C]) begin
          a_d     = a_in;
          b_d     = b_in;
          state_d = StExec;
        end else if (has_dir) begin
          op_d = op_step(op_q, press);
        end
      end
      StExec: begin
        en_c    = 1'b1;
        busy_c  = 1'b1;
        lat_d   = LatW'(ALU_LAT - 1);
        state_d = StWait;
      end
      StWait: begin
        busy_c = 1'b1;
        if (lat_q == '0) begin
          res_d   = alu.alu_res;
          done_c  = 1'b1;
          state_d = StShow;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      StShow: begin
        if (press[BTN_C]) begin
          a_d     = a_in;
          b_d     = b_in;
          state_d = StExec;
        end else if (has_dir) begin
          op_d    = op_step(op_q, press);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign alu.alu_op = op_q;
  assign alu.alu_a  = a_q;
  assign alu.alu_b  = b_q;
  assign alu.alu_en = en_c;
  assign result     = res_q;
  assign busy       = busy_c;
  assign done       = done_c;

endmodule
